// File: rtl/game_timer.sv
// game_timer: prescaled game clock with start/pause control, up/down counting,
// preload, wrap and expiry signalling. One clock (CLOCK10M), async active-low
// reset (RESET_N).
//
// Optional lap capture is compiled in when GAME_TIMER_LAP_EN is defined; it
// adds the LAP input and the lap_out / LAP_VALID outputs.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | stopped; prescaler holds; START moves to ST_RUN
// ST_RUN     | prescaler advances; counter steps once per prescaler period
// ST_PAUSED  | stopped mid-period; prescaler keeps its partial count
// ST_DONE    | down-count reached 0; only CLR, LOAD or reset leave
//
// Per-cycle priority: CLR > LOAD > PAUSE > START > tick.

module game_timer #(
    parameter int unsigned CNT_WIDTH = 10,
    parameter int unsigned PRESCALE  = 1000000,
    parameter int unsigned PRE_WIDTH = 24
) (
    input  logic                 CLOCK10M,
    input  logic                 RESET_N,
    input  logic                 CLR,
    input  logic                 START,
    input  logic                 PAUSE,
    input  logic                 DIR,
    input  logic                 LOAD,
    input  logic [CNT_WIDTH-1:0] LOAD_VAL,
`ifdef GAME_TIMER_LAP_EN
    input  logic                 LAP,
    output logic [CNT_WIDTH-1:0] lap_out,
    output logic                 LAP_VALID,
`endif
    output logic [CNT_WIDTH-1:0] counter_out,
    output logic                 TICK,
    output logic                 RUNNING,
    output logic                 EXPIRED,
    output logic                 WRAP
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Last prescaler value of a period; reaching it in RUN makes a tick cycle.
    localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(PRESCALE - 1);
    localparam logic [PRE_WIDTH-1:0] PRE_ONE  = PRE_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                 state_q,   state_d;
    logic [PRE_WIDTH-1:0]   pre_q,     pre_d;
    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
    logic                   tick_q,    tick_d;
    logic                   expired_q, expired_d;
    logic                   wrap_q,    wrap_d;
    logic                   running_q, running_d;

`ifdef GAME_TIMER_LAP_EN
    logic [CNT_WIDTH-1:0]   lap_q,       lap_d;
    logic                   lap_valid_q, lap_valid_d;
`endif

    // Next-state for FSM, prescaler, counter and one-cycle pulses.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        wrap_d    = 1'b0;

        if (CLR) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
        end else if (LOAD) begin
            // Preload restarts the period; a finished game becomes re-armable.
            cnt_d = LOAD_VAL;
            pre_d = '0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    // PAUSE outranks START, so a held PAUSE keeps us stopped.
                    if (START && !PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (PAUSE) begin
                        // Prescaler keeps its partial period across the pause.
                        state_d = ST_PAUSED;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (!DIR) begin
                            cnt_d  = cnt_q + CNT_ONE;
                            wrap_d = &cnt_q;
                        end else begin
                            // Down-count stops at 0; it never underflows.
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - CNT_ONE;
                            end
                            if (cnt_q == '0 || cnt_q == CNT_ONE) begin
                                expired_d = 1'b1;
                                state_d   = ST_DONE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

`ifdef GAME_TIMER_LAP_EN
    // Lap capture takes the counter value before any tick in the same cycle.
    always_comb begin
        lap_d       = lap_q;
        lap_valid_d = 1'b0;
        if (CLR) begin
            lap_d = '0;
        end else if (LAP) begin
            lap_d       = cnt_q;
            lap_valid_d = 1'b1;
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge CLOCK10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            expired_q   <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
`ifdef GAME_TIMER_LAP_EN
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            expired_q   <= expired_d;
            wrap_q      <= wrap_d;
            running_q   <= running_d;
`ifdef GAME_TIMER_LAP_EN
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
`endif
        end
    end

    assign counter_out = cnt_q;
    assign TICK        = tick_q;
    assign RUNNING     = running_q;
    assign EXPIRED     = expired_q;
    assign WRAP        = wrap_q;
`ifdef GAME_TIMER_LAP_EN
    assign lap_out     = lap_q;
    assign LAP_VALID   = lap_valid_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Directed testbench for game_timer with PRESCALE=4, CNT_WIDTH=4.
// Lap scenario is included when GAME_TIMER_LAP_EN is defined.

module tb_game_timer;

    logic       CLOCK10M;
    logic       RESET_N;
    logic       CLR, START, PAUSE, DIR, LOAD;
    logic [3:0] LOAD_VAL;
    logic [3:0] counter_out;
    logic       TICK, RUNNING, EXPIRED, WRAP;
`ifdef GAME_TIMER_LAP_EN
    logic       LAP;
    logic [3:0] lap_out;
    logic       LAP_VALID;
`endif

    int n_checks;
    int n_pass;

    game_timer #(.CNT_WIDTH(4), .PRESCALE(4), .PRE_WIDTH(4)) dut (
        .CLOCK10M    (CLOCK10M),
        .RESET_N     (RESET_N),
        .CLR         (CLR),
        .START       (START),
        .PAUSE       (PAUSE),
        .DIR         (DIR),
        .LOAD        (LOAD),
        .LOAD_VAL    (LOAD_VAL),
`ifdef GAME_TIMER_LAP_EN
        .LAP         (LAP),
        .lap_out     (lap_out),
        .LAP_VALID   (LAP_VALID),
`endif
        .counter_out (counter_out),
        .TICK        (TICK),
        .RUNNING     (RUNNING),
        .EXPIRED     (EXPIRED),
        .WRAP        (WRAP)
    );

    initial CLOCK10M = 1'b0;
    always #5 CLOCK10M = ~CLOCK10M;

    task automatic clk_step();
        @(posedge CLOCK10M);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLOCK10M);
        #1;
        n_checks++; if (counter_out !== 4'd0) $display("FAIL rst_cnt got %0d exp 0", counter_out); else n_pass++;
        n_checks++; if (TICK !== 1'b0) $display("FAIL rst_tick got %b exp 0", TICK); else n_pass++;
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL rst_running got %b exp 0", RUNNING); else n_pass++;
        n_checks++; if (EXPIRED !== 1'b0) $display("FAIL rst_expired got %b exp 0", EXPIRED); else n_pass++;
        n_checks++; if (WRAP !== 1'b0) $display("FAIL rst_wrap got %b exp 0", WRAP); else n_pass++;
        RESET_N = 1'b1;
        clk_step();
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL idle_after_rst got %b exp 0", RUNNING); else n_pass++;
    endtask

    task automatic test_count_up();
        logic [3:0] e;
        logic       et;
        DIR   = 1'b0;
        START = 1'b1;
        clk_step();
        n_checks++; if (RUNNING !== 1'b1) $display("FAIL up_enter_run got %b exp 1", RUNNING); else n_pass++;
        n_checks++; if (TICK !== 1'b0) $display("FAIL up_enter_tick got %b exp 0", TICK); else n_pass++;
        e = 4'd0;
        for (int k = 1; k <= 40; k++) begin
            clk_step();
            et = (k % 4 == 0);
            if (et) e = e + 4'd1;
            n_checks++; if (TICK !== et) $display("FAIL up_tick k=%0d got %b exp %b", k, TICK, et); else n_pass++;
            n_checks++; if (counter_out !== e) $display("FAIL up_cnt k=%0d got %0d exp %0d", k, counter_out, e); else n_pass++;
            n_checks++; if (RUNNING !== 1'b1) $display("FAIL up_running k=%0d got %b exp 1", k, RUNNING); else n_pass++;
            n_checks++; if (WRAP !== 1'b0) $display("FAIL up_wrap k=%0d got %b exp 0", k, WRAP); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] e;
        logic       et;
        int         wraps;
        e     = 4'd10;
        wraps = 0;
        for (int k = 1; k <= 24; k++) begin
            clk_step();
            et = (k % 4 == 0);
            if (et) e = e + 4'd1;
            if (WRAP === 1'b1) wraps++;
            n_checks++; if (counter_out !== e) $display("FAIL wrap_cnt k=%0d got %0d exp %0d", k, counter_out, e); else n_pass++;
            n_checks++; if (WRAP !== (k == 24)) $display("FAIL wrap_pulse k=%0d got %b exp %b", k, WRAP, (k == 24)); else n_pass++;
            n_checks++; if (RUNNING !== 1'b1) $display("FAIL wrap_running k=%0d got %b exp 1", k, RUNNING); else n_pass++;
        end
        n_checks++; if (wraps != 1) $display("FAIL wrap_count got %0d exp 1", wraps); else n_pass++;
        n_checks++; if (counter_out !== 4'd0) $display("FAIL wrap_final got %0d exp 0", counter_out); else n_pass++;
    endtask

    task automatic test_down_expire();
        logic [3:0] e;
        logic       et;
        START = 1'b0;
        CLR   = 1'b1;
        clk_step();
        CLR = 1'b0;
        n_checks++; if (counter_out !== 4'd0) $display("FAIL dn_clr_cnt got %0d exp 0", counter_out); else n_pass++;
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL dn_clr_running got %b exp 0", RUNNING); else n_pass++;
        LOAD = 1'b1; LOAD_VAL = 4'd3; DIR = 1'b1; START = 1'b1;
        clk_step();
        LOAD = 1'b0;
        n_checks++; if (counter_out !== 4'd3) $display("FAIL dn_load_cnt got %0d exp 3", counter_out); else n_pass++;
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL dn_load_blocks_start got %b exp 0", RUNNING); else n_pass++;
        clk_step();
        n_checks++; if (RUNNING !== 1'b1) $display("FAIL dn_start got %b exp 1", RUNNING); else n_pass++;
        e = 4'd3;
        for (int k = 1; k <= 12; k++) begin
            clk_step();
            et = (k % 4 == 0);
            if (et) e = e - 4'd1;
            n_checks++; if (counter_out !== e) $display("FAIL dn_cnt k=%0d got %0d exp %0d", k, counter_out, e); else n_pass++;
            n_checks++; if (TICK !== et) $display("FAIL dn_tick k=%0d got %b exp %b", k, TICK, et); else n_pass++;
            n_checks++; if (EXPIRED !== (k == 12)) $display("FAIL dn_expired k=%0d got %b exp %b", k, EXPIRED, (k == 12)); else n_pass++;
            n_checks++; if (RUNNING !== (k < 12)) $display("FAIL dn_running k=%0d got %b exp %b", k, RUNNING, (k < 12)); else n_pass++;
        end
        for (int k = 1; k <= 6; k++) begin
            clk_step();
            n_checks++; if (counter_out !== 4'd0) $display("FAIL done_hold_cnt k=%0d got %0d exp 0", k, counter_out); else n_pass++;
            n_checks++; if (RUNNING !== 1'b0) $display("FAIL done_ignore_start k=%0d got %b exp 0", k, RUNNING); else n_pass++;
            n_checks++; if ((TICK | EXPIRED) !== 1'b0) $display("FAIL done_pulses k=%0d got %b%b exp 00", k, TICK, EXPIRED); else n_pass++;
        end
        START = 1'b0; LOAD = 1'b1; LOAD_VAL = 4'd5;
        clk_step();
        LOAD = 1'b0;
        n_checks++; if (counter_out !== 4'd5) $display("FAIL done_load_cnt got %0d exp 5", counter_out); else n_pass++;
        START = 1'b1;
        clk_step();
        START = 1'b0;
        n_checks++; if (RUNNING !== 1'b1) $display("FAIL done_load_rearm got %b exp 1", RUNNING); else n_pass++;
    endtask

    task automatic test_down_from_zero();
        CLR = 1'b1;
        clk_step();
        CLR = 1'b0; DIR = 1'b1; START = 1'b1;
        clk_step();
        n_checks++; if (RUNNING !== 1'b1) $display("FAIL z_run got %b exp 1", RUNNING); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            n_checks++; if (counter_out !== 4'd0) $display("FAIL z_cnt k=%0d got %0d exp 0", k, counter_out); else n_pass++;
            n_checks++; if (EXPIRED !== (k == 4)) $display("FAIL z_expired k=%0d got %b exp %b", k, EXPIRED, (k == 4)); else n_pass++;
            n_checks++; if (RUNNING !== (k < 4)) $display("FAIL z_running k=%0d got %b exp %b", k, RUNNING, (k < 4)); else n_pass++;
        end
        START = 1'b0;
    endtask

    task automatic test_pause();
        CLR = 1'b1;
        clk_step();
        CLR = 1'b0; DIR = 1'b0; START = 1'b1;
        clk_step();
        n_checks++; if (RUNNING !== 1'b1) $display("FAIL p_run got %b exp 1", RUNNING); else n_pass++;
        clk_step();
        clk_step();
        START = 1'b0; PAUSE = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            clk_step();
            n_checks++; if (RUNNING !== 1'b0) $display("FAIL p_running k=%0d got %b exp 0", k, RUNNING); else n_pass++;
            n_checks++; if (TICK !== 1'b0) $display("FAIL p_tick k=%0d got %b exp 0", k, TICK); else n_pass++;
            n_checks++; if (counter_out !== 4'd0) $display("FAIL p_cnt k=%0d got %0d exp 0", k, counter_out); else n_pass++;
        end
        PAUSE = 1'b0; START = 1'b1;
        clk_step();
        n_checks++; if (RUNNING !== 1'b1) $display("FAIL p_resume got %b exp 1", RUNNING); else n_pass++;
        clk_step();
        n_checks++; if (TICK !== 1'b0) $display("FAIL p_resume_t1 got %b exp 0", TICK); else n_pass++;
        clk_step();
        n_checks++; if (TICK !== 1'b1) $display("FAIL p_resume_t2 got %b exp 1", TICK); else n_pass++;
        n_checks++; if (counter_out !== 4'd1) $display("FAIL p_resume_cnt got %0d exp 1", counter_out); else n_pass++;
    endtask

    task automatic test_clr_load();
        // Advance to prescaler=3 so the CLR/LOAD cycle would otherwise tick.
        repeat (3) clk_step();
        CLR = 1'b1; LOAD = 1'b1; LOAD_VAL = 4'd9;
        clk_step();
        CLR = 1'b0; LOAD = 1'b0; START = 1'b0;
        n_checks++; if (counter_out !== 4'd0) $display("FAIL cl_cnt got %0d exp 0", counter_out); else n_pass++;
        n_checks++; if (TICK !== 1'b0) $display("FAIL cl_tick got %b exp 0", TICK); else n_pass++;
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL cl_running got %b exp 0", RUNNING); else n_pass++;
        clk_step();
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL cl_idle got %b exp 0", RUNNING); else n_pass++;
    endtask

    task automatic test_async_reset();
        DIR = 1'b0; START = 1'b1;
        clk_step();
        repeat (4) clk_step();
        n_checks++; if (TICK !== 1'b1) $display("FAIL ar_pre_tick got %b exp 1", TICK); else n_pass++;
        n_checks++; if (counter_out !== 4'd1) $display("FAIL ar_pre_cnt got %0d exp 1", counter_out); else n_pass++;
        #3 RESET_N = 1'b0;
        #1;
        n_checks++; if (counter_out !== 4'd0) $display("FAIL ar_cnt got %0d exp 0", counter_out); else n_pass++;
        n_checks++; if (TICK !== 1'b0) $display("FAIL ar_tick got %b exp 0", TICK); else n_pass++;
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL ar_running got %b exp 0", RUNNING); else n_pass++;
        START = 1'b0;
        #2 RESET_N = 1'b1;
        clk_step();
        clk_step();
        n_checks++; if (counter_out !== 4'd0) $display("FAIL ar_post_cnt got %0d exp 0", counter_out); else n_pass++;
        n_checks++; if (RUNNING !== 1'b0) $display("FAIL ar_post_running got %b exp 0", RUNNING); else n_pass++;
    endtask

`ifdef GAME_TIMER_LAP_EN
    task automatic test_lap();
        CLR = 1'b1;
        clk_step();
        CLR = 1'b0; LOAD = 1'b1; LOAD_VAL = 4'd7;
        clk_step();
        LOAD = 1'b0; LAP = 1'b1;
        clk_step();
        LAP = 1'b0;
        n_checks++; if (lap_out !== 4'd7) $display("FAIL lap_val got %0d exp 7", lap_out); else n_pass++;
        n_checks++; if (LAP_VALID !== 1'b1) $display("FAIL lap_valid got %b exp 1", LAP_VALID); else n_pass++;
        clk_step();
        n_checks++; if (LAP_VALID !== 1'b0) $display("FAIL lap_valid_pulse got %b exp 0", LAP_VALID); else n_pass++;
        n_checks++; if (lap_out !== 4'd7) $display("FAIL lap_hold got %0d exp 7", lap_out); else n_pass++;
        LOAD = 1'b1; LOAD_VAL = 4'd8;
        clk_step();
        LOAD = 1'b0; DIR = 1'b0; START = 1'b1;
        clk_step();
        repeat (3) clk_step();
        LAP = 1'b1;
        clk_step();
        LAP = 1'b0;
        n_checks++; if (TICK !== 1'b1) $display("FAIL lap_tick got %b exp 1", TICK); else n_pass++;
        n_checks++; if (counter_out !== 4'd9) $display("FAIL lap_tick_cnt got %0d exp 9", counter_out); else n_pass++;
        n_checks++; if (lap_out !== 4'd8) $display("FAIL lap_pretick got %0d exp 8", lap_out); else n_pass++;
        CLR = 1'b1; START = 1'b0;
        clk_step();
        CLR = 1'b0;
        n_checks++; if (lap_out !== 4'd0) $display("FAIL lap_clr got %0d exp 0", lap_out); else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        RESET_N  = 1'b0;
        CLR      = 1'b0;
        START    = 1'b0;
        PAUSE    = 1'b0;
        DIR      = 1'b0;
        LOAD     = 1'b0;
        LOAD_VAL = 4'd0;
`ifdef GAME_TIMER_LAP_EN
        LAP      = 1'b0;
`endif
        test_reset();
        test_count_up();
        test_wrap();
        test_down_expire();
        test_down_from_zero();
        test_pause();
        test_clr_load();
        test_async_reset();
`ifdef GAME_TIMER_LAP_EN
        test_lap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
